// File: rtl/a1csah_pkg.sv
// Shared definitions for the a1csah carry-select adder family:
// block-count helper, parameter sanity check and per-block flag record.
package a1csah_pkg;

    function automatic int nblk(input int n, input int k);
        return n / k;
    endfunction

    function automatic bit params_ok(input int n, input int k);
        return (k >= 2) && ((n % k) == 0);
    endfunction

    typedef struct packed {
        logic g;
        logic p;
    } blk_gp_t;

endpackage

// File: rtl/a1csah_pipe_rbk.sv
// K-bit conditional add-one: rs = s + sel, implemented as the ripple of
// "all lower bits are ones" that flips each bit.
module a1csah_pipe_rbk #(
    parameter int K = 4
) (
    input  logic         sel,
    input  logic [K-1:0] s,
    output logic [K-1:0] rs
);

    logic w_run;

    always_comb begin
        rs    = '0;
        w_run = sel;
        for (int i = 0; i < K; i++) begin
            rs[i] = s[i] ^ w_run;
            w_run = w_run & s[i];
        end
    end

endmodule

// File: rtl/a1csah_pipe.sv
// Two-stage pipelined add-one carry-select adder/subtractor with
// valid/ready handshakes; stage 1 forms block sums, stage 2 resolves carries.
module a1csah_pipe
    import a1csah_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int NB = nblk(N, K);

    if (!params_ok(N, K)) begin : g_param_err
        $error("a1csah_pipe: N must be a multiple of K and K >= 2");
    end

    typedef struct packed {
        logic [K-1:0] s0;
        blk_gp_t      gp;
    } blk_rec_t;

    logic [N-1:0]          w_beff;
    logic                  w_ceff;
    logic                  w_adv2;
    logic                  w_accept;
    logic                  w_cmsb;
    logic [N-1:0]          w_sum;
    logic [NB:0]           w_c;
    blk_rec_t [NB-1:0]     w_blk;

    blk_rec_t [NB-1:0]     r_blk;
    logic                  r_c0;
    logic                  r_msbx;
    logic                  r_v1;
    logic                  r_v2;
    logic [N-1:0]          r_sum;
    logic                  r_cout;
    logic                  r_ovf;

    assign w_beff   = sub ? ~b : b;
    assign w_ceff   = cin ^ sub;
    assign w_adv2   = ~r_v2 | out_ready;
    assign in_ready = ~r_v1 | w_adv2;
    assign w_accept = in_valid & in_ready;
    assign w_c[0]   = r_c0;

    for (genvar j = 0; j < NB; j++) begin : g_blk
        logic [K:0] w_add;

        assign w_add          = {1'b0, a[j*K +: K]} + {1'b0, w_beff[j*K +: K]};
        assign w_blk[j].s0    = w_add[K-1:0];
        assign w_blk[j].gp.g  = w_add[K];
        assign w_blk[j].gp.p  = &w_add[K-1:0];
        assign w_c[j+1]       = r_blk[j].gp.g | (r_blk[j].gp.p & w_c[j]);

        a1csah_pipe_rbk #(.K(K)) u_rbk (
            .sel (w_c[j]),
            .s   (r_blk[j].s0),
            .rs  (w_sum[j*K +: K])
        );
    end

    // Carry into the MSB is recovered from the final MSB and its operand XOR.
    assign w_cmsb = w_sum[N-1] ^ r_msbx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_blk  <= '0;
            r_c0   <= 1'b0;
            r_msbx <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (in_ready) begin
                r_v1 <= in_valid;
            end
            if (w_accept) begin
                r_blk  <= w_blk;
                r_c0   <= w_ceff;
                r_msbx <= a[N-1] ^ w_beff[N-1];
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
            end
            if (w_adv2 && r_v1) begin
                r_sum  <= w_sum;
                r_cout <= w_c[NB];
                r_ovf  <= w_c[NB] ^ w_cmsb;
            end
        end
    end

    assign out_valid = r_v2;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_a1csah_pipe.sv
// Directed and reference-model checks for a1csah_pipe at N=16/K=4 and N=8/K=2.
module tb_a1csah_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, out_ready, cin, sub;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;

    logic        in_valid8, out_ready8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  sum8;

    int vectors = 0;
    int miscompares = 0;

    a1csah_pipe #(.N(16), .K(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    a1csah_pipe #(.N(8), .K(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // Returns {ovf, cout, sum} for a w-bit operation using plain integer arithmetic.
    function automatic logic [17:0] ref_model(input int w, input logic [15:0] x, input logic [15:0] y,
                                              input logic ci, input logic sb);
        int unsigned mask, lowm, be, ce, full, low;
        mask = (32'd1 << w) - 32'd1;
        lowm = (32'd1 << (w - 1)) - 32'd1;
        be   = sb ? ((~{16'h0, y}) & mask) : {16'h0, y};
        ce   = {31'd0, ci ^ sb};
        full = {16'h0, x} + be + ce;
        low  = ({16'h0, x} & lowm) + (be & lowm) + ce;
        return {full[w] ^ low[w-1], full[w], full[15:0] & mask[15:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, ovf, cout, sum} !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got valid=%b ovf=%b cout=%b sum=%h expected all zero",
                     out_valid, ovf, cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h8000};
        logic [15:0] tbv[4] = '{16'h0001, 16'h0000, 16'h0007, 16'h0001};
        logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [17:0] te [4] = '{{2'b00, 16'h0100}, {2'b01, 16'h0000},
                                {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            a = ta[i]; b = tbv[i]; cin = tc[i]; sub = ts[i];
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_in_ready: got %b expected 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_early_valid: got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            vectors++;
            if ({out_valid, ovf, cout, sum} !== {1'b1, te[i]}) begin
                miscompares++;
                $display("[TB] FAIL directed%0d_result: got v=%b ovf=%b cout=%b sum=%h expected v=1 ovf=%b cout=%b sum=%h",
                         i, out_valid, ovf, cout, sum, te[i][17], te[i][16], te[i][15:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_sum [3] = '{16'd3, 16'd7, 16'd11};
        out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; a = 16'd1; b = 16'd2;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_accept0: got in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        a = 16'd3; b = 16'd4;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_accept1: got in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        a = 16'd5; b = 16'd6;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({in_ready, out_valid, sum} !== {2'b01, exp_sum[0]}) begin
                miscompares++;
                $display("[TB] FAIL bp_stall%0d: got in_ready=%b valid=%b sum=%h expected in_ready=0 valid=1 sum=%h",
                         k, in_ready, out_valid, sum, exp_sum[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({out_valid, sum} !== {1'b1, exp_sum[k]}) begin
                miscompares++;
                $display("[TB] FAIL bp_drain%0d: got valid=%b sum=%h expected valid=1 sum=%h",
                         k, out_valid, sum, exp_sum[k]);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        a = 16'h4321;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL midop_full: got valid=%b in_ready=%b expected valid=1 in_ready=0",
                     out_valid, in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({out_valid, cout, ovf, in_ready, sum} !== {4'b0001, 16'h0}) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: got valid=%b cout=%b ovf=%b in_ready=%b sum=%h expected 0 0 0 1 0000",
                     out_valid, cout, ovf, in_ready, sum);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midop_stale%0d: got valid=%b expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_stream16();
        logic [17:0] q[$];
        logic [17:0] e;
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                q.push_back(ref_model(16, a, b, cin, sub));
            end else begin
                in_valid = 1'b0;
            end
            vectors++;
            if (c >= 2 && c < 10) begin
                e = q.pop_front();
                if ({out_valid, ovf, cout, sum} !== {1'b1, e}) begin
                    miscompares++;
                    $display("[TB] FAIL stream16_op%0d: got v=%b ovf=%b cout=%b sum=%h expected v=1 ovf=%b cout=%b sum=%h",
                             c - 2, out_valid, ovf, cout, sum, e[17], e[16], e[15:0]);
                end
            end else if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stream16_idle%0d: got valid=%b expected 0", c, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stream8();
        logic [17:0] q[$];
        logic [17:0] e;
        out_ready8 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                in_valid8 = 1'b1;
                a8 = 8'($urandom); b8 = 8'($urandom);
                cin8 = 1'($urandom); sub8 = 1'($urandom);
                if (c == 0) begin
                    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1;
                end
                q.push_back(ref_model(8, {8'h0, a8}, {8'h0, b8}, cin8, sub8));
            end else begin
                in_valid8 = 1'b0;
            end
            vectors++;
            if (c >= 2 && c < 10) begin
                e = q.pop_front();
                if ({out_valid8, ovf8, cout8, sum8} !== {1'b1, e[17:16], e[7:0]}) begin
                    miscompares++;
                    $display("[TB] FAIL stream8_op%0d: got v=%b ovf=%b cout=%b sum=%h expected v=1 ovf=%b cout=%b sum=%h",
                             c - 2, out_valid8, ovf8, cout8, sum8, e[17], e[16], e[7:0]);
                end
            end else if (out_valid8 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stream8_idle%0d: got valid=%b expected 0", c, out_valid8);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_stream16();
        test_stream8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
